// File: rtl/pslip_pkg.sv
// Shared sizing constants and FSM state type for the PSLIP output-port grant arbiter.
package pslip_pkg;

    localparam int N  = 32;
    localparam int P  = 16;
    localparam int PW = $clog2(P);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEL     = 2'd1,
        GRANT   = 2'd2,
        MATCHED = 2'd3
    } state_t;

endpackage

// File: rtl/pslip_rr_pick.sv
// Round-robin one-hot picker: first set mask bit at or above ptr, wrapping modulo N.
module pslip_rr_pick #(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && mask[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pslip_grant_arb.sv
// PSLIP output-port grant arbiter: highest snapshot priority wins, ties broken round-robin.
// Optional accept-wait timeout is enabled with macro PSLIP_GRANT_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start; snapshot of pri/first_iter taken on start
// SEL     | two cycles: register max-priority mask, then pick grant or finish empty
// GRANT   | grant presented, waiting for the input side's accept/reject
// MATCHED | grant accepted; held until slot_clr
module pslip_grant_arb #(
    parameter int N   = pslip_pkg::N,
    parameter int P   = pslip_pkg::P,
    parameter int TMO = 8,
    localparam int PW = $clog2(P),
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] pri [0:N-1],
    input  logic          start,
    input  logic          first_iter,
    input  logic          acc_valid,
    input  logic          acc,
    input  logic          slot_clr,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic          done,
    output logic          matched,
`ifdef PSLIP_GRANT_TIMEOUT_EN
    output logic          timeout,
`endif
    output logic [IW-1:0] rr_ptr
);

    import pslip_pkg::*;

    state_t        state;
    logic          sel_stage;
    logic [PW-1:0] snap [0:N-1];
    logic          snap_first;
    logic [N-1:0]  mask_q;
    logic [IW-1:0] grant_idx;
    logic [PW-1:0] pri_max;
    logic [N-1:0]  mask;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;

`ifdef PSLIP_GRANT_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt;
`else
    // GRANT waits indefinitely; TMO stays in the parameter list so both builds share it.
    if (TMO < 0) begin : g_tmo_unused
    end
`endif

    always_comb begin
        pri_max = '0;
        mask    = '0;
        for (int i = 0; i < N; i++) begin
            if (snap[i] > pri_max) pri_max = snap[i];
        end
        for (int i = 0; i < N; i++) begin
            mask[i] = (pri_max != '0) && (snap[i] == pri_max);
        end
    end

    pslip_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .mask   (mask_q),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel_stage   <= 1'b0;
            snap_first  <= 1'b0;
            mask_q      <= '0;
            grant_idx   <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            done        <= 1'b0;
            matched     <= 1'b0;
            rr_ptr      <= '0;
            for (int i = 0; i < N; i++) snap[i] <= '0;
`ifdef PSLIP_GRANT_TIMEOUT_EN
            timeout     <= 1'b0;
            tmo_cnt     <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PSLIP_GRANT_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            // slot_clr overrides every other event, including a same-cycle accept
            if (slot_clr) begin
                state       <= IDLE;
                sel_stage   <= 1'b0;
                grant       <= '0;
                grant_valid <= 1'b0;
                matched     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            snap       <= pri;
                            snap_first <= first_iter;
                            sel_stage  <= 1'b0;
                            state      <= SEL;
                        end
                    end
                    SEL: begin
                        if (!sel_stage) begin
                            mask_q    <= mask;
                            sel_stage <= 1'b1;
                        end else begin
                            sel_stage <= 1'b0;
                            if (mask_q == '0) begin
                                done  <= 1'b1;
                                grant <= '0;
                                state <= IDLE;
                            end else begin
                                grant       <= pick_onehot;
                                grant_idx   <= pick_idx;
                                grant_valid <= 1'b1;
                                state       <= GRANT;
`ifdef PSLIP_GRANT_TIMEOUT_EN
                                tmo_cnt     <= TW'(TMO - 1);
`endif
                            end
                        end
                    end
                    GRANT: begin
                        if (acc_valid) begin
                            done <= 1'b1;
                            if (acc) begin
                                matched <= 1'b1;
                                state   <= MATCHED;
                                if (snap_first) begin
                                    rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
                                end
                            end else begin
                                grant       <= '0;
                                grant_valid <= 1'b0;
                                state       <= IDLE;
                            end
`ifdef PSLIP_GRANT_TIMEOUT_EN
                        end else if (tmo_cnt == '0) begin
                            done        <= 1'b1;
                            timeout     <= 1'b1;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt - 1'b1;
`endif
                        end
                    end
                    MATCHED: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pslip_grant_arb.sv
// Randomized self-checking bench for pslip_grant_arb against a max-priority / round-robin model.
module tb_pslip_grant_arb;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pri [0:N-1];
    logic       start, first_iter, acc_valid, acc, slot_clr;
    logic [N-1:0] grant;
    logic       grant_valid, done, matched;
    logic [4:0] rr_ptr;
`ifdef PSLIP_GRANT_TIMEOUT_EN
    logic       timeout;
`endif

    int checks   = 0;
    int failures = 0;
    int m_rr     = 0;
    logic [N-1:0] g_seen;

    pslip_grant_arb dut (
        .clk         (clk),
        .rst         (rst),
        .pri         (pri),
        .start       (start),
        .first_iter  (first_iter),
        .acc_valid   (acc_valid),
        .acc         (acc),
        .slot_clr    (slot_clr),
        .grant       (grant),
        .grant_valid (grant_valid),
        .done        (done),
        .matched     (matched),
`ifdef PSLIP_GRANT_TIMEOUT_EN
        .timeout     (timeout),
`endif
        .rr_ptr      (rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Winner = index with the highest nonzero priority at the smallest forward distance from ptr.
    function automatic int model_pick(input logic [3:0] p [0:N-1], input int ptr);
        int best  = 0;
        int sel   = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) if (int'(p[i]) > best) best = int'(p[i]);
        if (best == 0) return -1;
        for (int i = 0; i < N; i++) begin
            if (int'(p[i]) == best && ((i - ptr + N) % N) < bestd) begin
                bestd = (i - ptr + N) % N;
                sel   = i;
            end
        end
        return sel;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pri();
        for (int i = 0; i < N; i++) pri[i] = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst  = 1'b0;
        m_rr = 0;
    endtask

    // action: 0 = accept, 1 = reject, 2 = accept together with slot_clr
    task automatic run_iter(input bit fi, input int action, input int waitc);
        int exp_idx;
        logic [N-1:0] exp_g;
        exp_idx = model_pick(pri, m_rr);
        g_seen  = '0;
        start = 1'b1;
        first_iter = fi;
        step();
        start = 1'b0;
        first_iter = 1'($urandom);
        for (int i = 0; i < N; i++) pri[i] = 4'($urandom);
        check_val("sel1_gv", grant_valid, 0);
        step();
        check_val("sel2_gv", grant_valid, 0);
        check_val("sel2_done", done, 0);
        step();
        if (exp_idx < 0) begin
            check_val("empty_done", done, 1);
            check_val("empty_gv", grant_valid, 0);
            check_val("empty_grant", grant, 0);
            check_val("empty_rr", rr_ptr, m_rr);
            step();
            check_val("empty_done_off", done, 0);
            return;
        end
        exp_g  = '0;
        exp_g[exp_idx] = 1'b1;
        g_seen = grant;
        check_val("grant", grant, exp_g);
        check_val("grant_gv", grant_valid, 1);
        check_val("grant_done", done, 0);
        for (int w = 0; w < waitc; w++) begin
            start = 1'($urandom);
            step();
            start = 1'b0;
            check_val("wait_grant", grant, exp_g);
            check_val("wait_done", done, 0);
        end
        acc_valid = 1'b1;
        acc       = (action != 1);
        slot_clr  = (action == 2);
        step();
        acc_valid = 1'b0;
        slot_clr  = 1'b0;
        if (action == 0) begin
            if (fi) m_rr = (exp_idx + 1) % N;
            check_val("acc_matched", matched, 1);
            check_val("acc_done", done, 1);
            check_val("acc_grant", grant, exp_g);
            check_val("acc_gv", grant_valid, 1);
            check_val("acc_rr", rr_ptr, m_rr);
            start     = 1'b1;
            acc_valid = 1'b1;
            acc       = 1'b0;
            step();
            start     = 1'b0;
            acc_valid = 1'b0;
            check_val("hold_matched", matched, 1);
            check_val("hold_done", done, 0);
            check_val("hold_grant", grant, exp_g);
            slot_clr = 1'b1;
            step();
            slot_clr = 1'b0;
            check_val("clr_grant", grant, 0);
            check_val("clr_gv", grant_valid, 0);
            check_val("clr_matched", matched, 0);
            check_val("clr_done", done, 0);
            check_val("clr_rr", rr_ptr, m_rr);
        end else if (action == 1) begin
            check_val("rej_grant", grant, 0);
            check_val("rej_gv", grant_valid, 0);
            check_val("rej_done", done, 1);
            check_val("rej_matched", matched, 0);
            check_val("rej_rr", rr_ptr, m_rr);
        end else begin
            check_val("race_grant", grant, 0);
            check_val("race_gv", grant_valid, 0);
            check_val("race_matched", matched, 0);
            check_val("race_done", done, 0);
            check_val("race_rr", rr_ptr, m_rr);
        end
        step();
        check_val("post_done", done, 0);
    endtask

    initial begin
        start = 0; first_iter = 0; acc_valid = 0; acc = 0; slot_clr = 0;
        clear_pri();
        do_reset();
        check_val("rst_grant", grant, 0);
        check_val("rst_gv", grant_valid, 0);
        check_val("rst_done", done, 0);
        check_val("rst_matched", matched, 0);
        check_val("rst_rr", rr_ptr, 0);

        // empty request set
        clear_pri();
        run_iter(1'b1, 0, 0);
        check_val("empty_rr0", rr_ptr, 0);

        // tie between 3 and 9, pointer moves past the winner
        clear_pri(); pri[3] = 5; pri[9] = 5; pri[7] = 2;
        run_iter(1'b1, 0, 2);
        check_val("d36_g1", g_seen, 64'h8);
        check_val("d36_rr1", rr_ptr, 4);
        clear_pri(); pri[3] = 5; pri[9] = 5; pri[7] = 2;
        run_iter(1'b1, 0, 1);
        check_val("d36_g2", g_seen, 64'h200);

        // later iteration does not move the pointer
        do_reset();
        clear_pri(); pri[3] = 5; pri[9] = 5; pri[7] = 2;
        run_iter(1'b0, 0, 0);
        check_val("d37_g", g_seen, 64'h8);
        check_val("d37_rr", rr_ptr, 0);

        // wrap-around at the top index
        do_reset();
        clear_pri(); pri[30] = 1;
        run_iter(1'b1, 0, 0);
        check_val("d38_rr31", rr_ptr, 31);
        clear_pri(); pri[31] = 7; pri[0] = 7;
        run_iter(1'b1, 0, 0);
        check_val("d38_g", g_seen, 64'h80000000);
        check_val("d38_rr0", rr_ptr, 0);

        // accept and slot_clr in the same cycle
        clear_pri(); pri[12] = 9;
        run_iter(1'b1, 2, 1);
        check_val("d39_rr", rr_ptr, 0);

`ifdef PSLIP_GRANT_TIMEOUT_EN
        clear_pri(); pri[5] = 3;
        start = 1'b1; first_iter = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_val("tmo_gv_up", grant_valid, 1);
        for (int c = 0; c < 7; c++) begin
            step();
            check_val("tmo_gv_hold", grant_valid, 1);
            check_val("tmo_early", timeout, 0);
        end
        step();
        check_val("tmo_pulse", timeout, 1);
        check_val("tmo_done", done, 1);
        check_val("tmo_grant", grant, 0);
        step();
        check_val("tmo_off", timeout, 0);
`else
        clear_pri(); pri[20] = 4;
        run_iter(1'b1, 1, 20);
`endif

        // reset in the middle of GRANT aborts immediately
        clear_pri(); pri[6] = 2;
        start = 1'b1; first_iter = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_val("mid_gv", grant_valid, 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_grant", grant, 0);
        check_val("mid_rst_gv", grant_valid, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_matched", matched, 0);
        check_val("mid_rst_rr", rr_ptr, 0);
        step();
        rst  = 1'b0;
        m_rr = 0;
        step();
        check_val("mid_post_done", done, 0);

        for (int it = 0; it < 150; it++) begin
            for (int i = 0; i < N; i++)
                pri[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 9) == 0) clear_pri();
            if ($urandom_range(0, 4) == 0) begin
                acc_valid = 1'b1;
                acc       = 1'b1;
                step();
                acc_valid = 1'b0;
                check_val("idle_acc_matched", matched, 0);
                check_val("idle_acc_done", done, 0);
            end
            run_iter(1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            check_val("rand_rr", rr_ptr, m_rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
